// File: rtl/config_loader_pkg.sv
// Shared types and constants for the config-chain loader: FSM encoding,
// CRC-16-CCITT constants and a constant-evaluable ceil(log2) helper.
package config_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/config_chain_loader_crc16_serial.sv
// Bit-serial CRC-16-CCITT (poly 0x1021, init 0xFFFF), one bit per enabled cycle.
// clr has priority over en and restores the init value.
module crc16_serial
    import config_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] crc_q, crc_d;
    logic        feedback;

    assign feedback = crc_q[15] ^ bit_in;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = CRC16_INIT;
        end else if (en) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/config_chain_loader.sv
// Serialises bitstream words LSB-first into the head of the config shift chain.
// Optional readback/CRC check of the chain is built when CONFIG_CHAIN_READBACK_EN is defined.
module config_chain_loader
    import config_loader_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = clog2(CHAIN_LEN + 1)
) (
    input  logic              config_clk,
    input  logic              config_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              chain_out,
    output logic              chain_shift_en,
    input  logic              chain_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output state_e            dbg_state
);

    localparam int                PEND_W    = clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [PEND_W-1:0] FULL_WORD = PEND_W'(WORD_W);

    // s_valid/s_ready: a word transfers on any cycle where both are high at the clock edge.
    state_e             state_q, state_d;
    logic [WORD_W-1:0]  data_q, data_d;
    logic [PEND_W-1:0]  pend_q, pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_q, out_d;
    logic               shift_en_q, shift_en_d;
    logic               fin_q, fin_d;
    logic               done_q, done_d;
    logic               start_acc, load_shift, last_load, verify_last, accept;

    assign start_acc   = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign load_shift  = (state_q == ST_LOAD) && (pend_q != '0);
    assign last_load   = load_shift && (cnt_q == LAST_BIT);
    assign verify_last = (state_q == ST_VERIFY) && (cnt_q == LAST_BIT);
    assign accept      = s_valid && s_ready;

    always_ff @(posedge config_clk or negedge config_reset) begin
        if (!config_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_LOAD;
`ifdef CONFIG_CHAIN_READBACK_EN
            ST_LOAD:          if (last_load) state_d = ST_VERIFY;
`else
            ST_LOAD:          if (last_load) state_d = ST_DONE;
`endif
            ST_VERIFY:        if (verify_last) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Taking a new word while the last pending bit leaves keeps the stream bubble-free.
    always_comb begin
        s_ready   = (state_q == ST_LOAD) && (pend_q <= PEND_W'(1));
        busy      = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
        dbg_state = state_q;
    end

    always_comb begin
        data_d     = data_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        shift_en_d = 1'b0;
        fin_d      = 1'b0;
        done_d     = done_q | fin_q;
        if (start_acc) begin
            pend_d = '0;
            cnt_d  = '0;
            done_d = 1'b0;
        end
        if (load_shift) begin
            shift_en_d = 1'b1;
            out_d      = data_q[0];
            data_d     = data_q >> 1;
            pend_d     = pend_q - 1'b1;
            cnt_d      = cnt_q + 1'b1;
        end
        if (accept) begin
            data_d = s_data;
            pend_d = FULL_WORD;
        end
        // Bits of the final word beyond the chain length are dropped here.
        if (last_load) begin
            pend_d = '0;
`ifdef CONFIG_CHAIN_READBACK_EN
            cnt_d  = '0;
`else
            fin_d  = 1'b1;
`endif
        end
`ifdef CONFIG_CHAIN_READBACK_EN
        if (state_q == ST_VERIFY) begin
            shift_en_d = 1'b1;
            cnt_d      = verify_last ? '0 : cnt_q + 1'b1;
            fin_d      = verify_last;
        end
`endif
    end

    always_ff @(posedge config_clk or negedge config_reset) begin
        if (!config_reset) begin
            data_q     <= '0;
            pend_q     <= '0;
            cnt_q      <= '0;
            out_q      <= 1'b0;
            shift_en_q <= 1'b0;
            fin_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            data_q     <= data_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            shift_en_q <= shift_en_d;
            fin_q      <= fin_d;
            done_q     <= done_d;
        end
    end

    assign chain_shift_en = shift_en_q;
    assign done           = done_q;

`ifdef CONFIG_CHAIN_READBACK_EN
    logic        rb_q, chk_q, err_q;
    logic [15:0] crc_load, crc_rb;
    logic        mismatch;

    crc16_serial u_crc_load (
        .clk    (config_clk),
        .rst_n  (config_reset),
        .clr    (start_acc),
        .en     (load_shift),
        .bit_in (data_q[0]),
        .crc    (crc_load)
    );

    crc16_serial u_crc_rb (
        .clk    (config_clk),
        .rst_n  (config_reset),
        .clr    (start_acc),
        .en     (rb_q),
        .bit_in (chain_in),
        .crc    (crc_rb)
    );

    assign mismatch = crc_load != crc_rb;

    always_ff @(posedge config_clk or negedge config_reset) begin
        if (!config_reset) begin
            rb_q  <= 1'b0;
            chk_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            rb_q  <= (state_q == ST_VERIFY);
            chk_q <= fin_q;
            err_q <= start_acc ? 1'b0 : (err_q | (chk_q & mismatch));
        end
    end

    // A registered recirculation loop would hold CHAIN_LEN+1 bits and rotate the
    // content, so during readback the chain's own output flop feeds its input directly.
    assign chain_out = rb_q ? chain_in : out_q;
    assign err       = err_q | (chk_q & mismatch);
`else
    logic unused_chain_in;

    assign unused_chain_in = chain_in;
    assign chain_out       = out_q;
    assign err             = 1'b0;
`endif

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader with a 40-bit chain model; build with or without
// CONFIG_CHAIN_READBACK_EN to exercise the matching variant.
`timescale 1ns/1ps
module tb_config_chain_loader;
    import config_loader_pkg::*;

    localparam int WORD_W    = 32;
    localparam int CHAIN_LEN = 40;
`ifdef CONFIG_CHAIN_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int EXP_SHIFTS = RB ? 2 * CHAIN_LEN : CHAIN_LEN;

    logic              config_clk;
    logic              config_reset;
    logic              start;
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              chain_out;
    logic              chain_shift_en;
    logic              chain_in;
    logic              busy;
    logic              done;
    logic              err;
    state_e            dbg_state;

    config_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
        .config_clk     (config_clk),
        .config_reset   (config_reset),
        .start          (start),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .chain_out      (chain_out),
        .chain_shift_en (chain_shift_en),
        .chain_in       (chain_in),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        config_clk = 1'b0;
        forever #5 config_clk = ~config_clk;
    end

    // ---------------- chain model: cell 0 at index 0, last cell drives chain_in ----------------
    logic [CHAIN_LEN-1:0] chain_q = '0;
    logic                 flip_in;

    assign chain_in = chain_q[CHAIN_LEN-1] ^ flip_in;

    always @(posedge config_clk) begin
        if (chain_shift_en) chain_q <= {chain_q[CHAIN_LEN-2:0], chain_out};
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [0:0] exp_q[$];

    int r_shifts, r_stalls, r_acc, r_done_cyc, r_rises, r_bit_err, r_last, r_bits_left;
    bit r_busy_ok;
    logic r_done_after_start, r_busy_after_start, r_err_after_start;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected chain image: stream bit i (words LSB-first) ends in cell CHAIN_LEN-1-i.
    function automatic logic [CHAIN_LEN-1:0] model_chain(input logic [WORD_W-1:0] w0,
                                                         input logic [WORD_W-1:0] w1);
        logic stream[$];
        logic [CHAIN_LEN-1:0] img;
        for (int i = 0; i < WORD_W; i++) stream.push_back(w0[i]);
        for (int i = 0; i < WORD_W; i++) stream.push_back(w1[i]);
        img = '0;
        for (int i = 0; i < CHAIN_LEN; i++) img[CHAIN_LEN-1-i] = stream[i];
        return img;
    endfunction

    // ---------------- driver ----------------
    task automatic run_load(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                            input int gap, input bit rand_valid, input int start_at,
                            input bit flip);
        logic [WORD_W-1:0] words[3];
        logic [CHAIN_LEN-1:0] img;
        int widx, gap_left, last, cyc;
        bit prev_done, start_sent;
        words[0] = w0;
        words[1] = w1;
        words[2] = $urandom();
        img = model_chain(w0, w1);
        exp_q.delete();
        for (int i = 0; i < CHAIN_LEN; i++) exp_q.push_back(img[CHAIN_LEN-1-i]);
        if (RB && !flip) begin
            for (int i = 0; i < CHAIN_LEN; i++) exp_q.push_back(img[CHAIN_LEN-1-i]);
        end
        r_shifts = 0; r_stalls = 0; r_acc = 0; r_done_cyc = -1; r_rises = 0;
        r_bit_err = 0; r_busy_ok = 1'b1;
        widx = 0; gap_left = gap; last = -1; cyc = 0; start_sent = 1'b0;
        start = 1'b1;
        @(posedge config_clk); #1;
        start = 1'b0;
        r_done_after_start = done;
        r_busy_after_start = busy;
        r_err_after_start  = err;
        prev_done = done;
        while (cyc < 400 && !(r_done_cyc >= 0 && cyc >= r_done_cyc + 4)) begin
            start = (start_at >= 0 && !start_sent && r_shifts == start_at);
            if (start) start_sent = 1'b1;
            s_data = words[widx];
            if (widx == 1 && gap_left > 0) s_valid = 1'b0;
            else if (rand_valid)           s_valid = ($urandom_range(0, 2) != 0);
            else                           s_valid = 1'b1;
            flip_in = flip && (r_shifts == CHAIN_LEN + CHAIN_LEN / 2);
            @(negedge config_clk);
            if (r_done_cyc < 0 && r_shifts < CHAIN_LEN - 1 && !busy) r_busy_ok = 1'b0;
            if (chain_shift_en) begin
                if (last >= 0) r_stalls += cyc - last - 1;
                last = cyc;
                if (exp_q.size() > 0) begin
                    if (chain_out !== exp_q.pop_front()) r_bit_err++;
                end
                r_shifts++;
            end
            if (s_valid && s_ready) begin
                r_acc++;
                if (widx < 2) widx++;
            end else if (widx == 1 && gap_left > 0 && s_ready) begin
                gap_left--;
            end
            if (done && !prev_done) begin
                r_rises++;
                if (r_done_cyc < 0) r_done_cyc = cyc;
            end
            prev_done = done;
            @(posedge config_clk); #1;
            start   = 1'b0;
            flip_in = 1'b0;
            cyc++;
        end
        s_valid     = 1'b0;
        r_last      = last;
        r_bits_left = exp_q.size();
    endtask

    task automatic verify_load(input string name, input logic [WORD_W-1:0] w0,
                               input logic [WORD_W-1:0] w1, input int exp_stalls,
                               input bit flip);
        check({name, "_done_clr"},   r_done_after_start, 0);
        check({name, "_err_clr"},    r_err_after_start, 0);
        check({name, "_busy_start"}, r_busy_after_start, 1);
        check({name, "_shifts"},     r_shifts, EXP_SHIFTS);
        if (exp_stalls >= 0) check({name, "_stalls"}, r_stalls, exp_stalls);
        check({name, "_bit_order"},  r_bit_err, 0);
        check({name, "_bits_left"},  r_bits_left, 0);
        check({name, "_words_acc"},  r_acc, 2);
        check({name, "_done_lat"},   r_done_cyc - r_last, 1);
        check({name, "_done_once"},  r_rises, 1);
        check({name, "_busy_hold"},  r_busy_ok, 1);
        if (!(flip && RB)) check({name, "_chain"}, chain_q, model_chain(w0, w1));
        check({name, "_err"},        err, flip && RB);
        check({name, "_done_stick"}, done, 1);
        check({name, "_ready_off"},  s_ready, 0);
        check({name, "_shift_off"},  chain_shift_en, 0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [WORD_W-1:0] w0;
        logic [WORD_W-1:0] w1;
        int                gap;
        int                start_at;
        bit                flip;
        int                exp_stalls;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cnt, cyc, start_at;
        logic [WORD_W-1:0] w0, w1;

        vecs[0] = '{32'hA5A5A5A5, 32'h000000FF, 0, -1, 1'b0, 0};
        vecs[1] = '{32'hA5A5A5A5, 32'h000000FF, 5, -1, 1'b0, 5};
        vecs[2] = '{32'h12345678, 32'hDEADBEEF, 2, 15, 1'b0, 2};
        vecs[3] = '{32'hA5A5A5A5, 32'h000000FF, 0, -1, 1'b1, 0};
        vecs[4] = '{32'hFFFFFFFF, 32'h00000000, 0, 0,  1'b0, 0};

        config_reset = 1'b0;
        start        = 1'b0;
        s_valid      = 1'b0;
        s_data       = '0;
        flip_in      = 1'b0;

        repeat (3) @(posedge config_clk);
        #1;
        check("rst_ready", s_ready, 0);
        check("rst_shift", chain_shift_en, 0);
        check("rst_out",   chain_out, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_err",   err, 0);
        check("rst_state", dbg_state, ST_IDLE);
        @(negedge config_clk);
        config_reset = 1'b1;
        @(posedge config_clk); #1;
        check("idle_state", dbg_state, ST_IDLE);
        check("idle_ready", s_ready, 0);

        for (int v = 0; v < 5; v++) begin
            run_load(vecs[v].w0, vecs[v].w1, vecs[v].gap, 1'b0, vecs[v].start_at, vecs[v].flip);
            verify_load($sformatf("vec%0d", v), vecs[v].w0, vecs[v].w1,
                        vecs[v].exp_stalls, vecs[v].flip);
        end

        // Asynchronous reset in the middle of a load, then a fresh full load.
        start = 1'b1;
        @(posedge config_clk); #1;
        start = 1'b0;
        cnt = 0;
        cyc = 0;
        while (cnt < 10 && cyc < 100) begin
            s_valid = 1'b1;
            s_data  = 32'h0F0F3C3C;
            @(negedge config_clk);
            if (chain_shift_en) cnt++;
            if (cnt < 10) begin
                @(posedge config_clk); #1;
            end
            cyc++;
        end
        check("midrst_wait", cnt, 10);
        #2 config_reset = 1'b0;
        #1;
        check("midrst_shift", chain_shift_en, 0);
        check("midrst_out",   chain_out, 0);
        check("midrst_ready", s_ready, 0);
        check("midrst_busy",  busy, 0);
        check("midrst_done",  done, 0);
        check("midrst_err",   err, 0);
        check("midrst_state", dbg_state, ST_IDLE);
        @(posedge config_clk); #1;
        check("midrst_hold", chain_shift_en, 0);
        @(negedge config_clk);
        config_reset = 1'b1;
        s_valid      = 1'b0;
        @(posedge config_clk); #1;
        check("postrst_state", dbg_state, ST_IDLE);
        run_load(32'hC3C3_0F0F, 32'h0000_005A, 0, 1'b0, -1, 1'b0);
        verify_load("postrst", 32'hC3C3_0F0F, 32'h0000_005A, 0, 1'b0);

        // Randomised words, random s_valid gaps, random ignored start pulses.
        for (int i = 0; i < 8; i++) begin
            w0 = $urandom();
            w1 = $urandom();
            start_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30)) : -1;
            run_load(w0, w1, 0, 1'b1, start_at, 1'b0);
            verify_load($sformatf("rnd%0d", i), w0, w1, -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
